// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment stage.
// Holds the FSM state encoding, funct3 size codes and access-shape helpers.
package lsu_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A0,
        S_D0,
        S_A1,
        S_D1,
        S_RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            F3_W:        size_mask = 4'b1111;
            default:     size_mask = 4'b0000;
        endcase
    endfunction

    // An access splits when its bytes run past lane 3 of the first word.
    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] o);
        case (funct3)
            F3_W:        is_split = (o != 2'd0);
            F3_H, F3_HU: is_split = (o == 2'd3);
            default:     is_split = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic write, input logic [2:0] funct3);
        if (write) is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else       is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                              (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Request/response and data-memory signals of the alignment stage.
// The slave modport is the stage; the master modport is requester plus memory.
interface lsu_align_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [3:0]            mem_wr;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr, mem_wd
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr, mem_wd
    );
endinterface

// File: rtl/lsu_lane_shift.sv
// Combinational lane steering: store lane masks/data per beat, load merge and extend.
module lsu_lane_shift
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  wr0,
    output logic [3:0]  wr1,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] ld_data
);
    logic [7:0]  mask8;
    logic [63:0] wide;
    logic [31:0] v;

    always_comb begin
        mask8 = {4'b0000, size_mask(funct3)} << offset;
        wide  = {32'h0000_0000, wdata} << {offset, 3'b000};
        v     = 32'({hi, lo} >> {offset, 3'b000});

        wr0 = mask8[3:0];
        wr1 = mask8[7:4];
        wd0 = wide[31:0];
        wd1 = wide[63:32];

        // Halfword replication only lines up with the lanes at even offsets.
        case (funct3)
            F3_B: begin
                wd0 = {WORD_BYTES{wdata[BYTE_W-1:0]}};
                wd1 = {WORD_BYTES{wdata[BYTE_W-1:0]}};
            end
            F3_H: begin
                if (!offset[0]) wd0 = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    ld_data = {{24{v[7]}}, v[7:0]};
            F3_BU:   ld_data = {24'h00_0000, v[7:0]};
            F3_H:    ld_data = {{16{v[15]}}, v[15:0]};
            F3_HU:   ld_data = {16'h0000, v[15:0]};
            default: ld_data = v;
        endcase
    end
endmodule

// File: rtl/lsu_align.sv
// Load/store alignment stage: turns one request into one or two word beats
// and returns merged, extended load data with a single-cycle response pulse.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic       clk,
    input  logic       reset,
    lsu_align_if.slave bus
);
    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [DATA_W-1:0]     hi_q, hi_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0]     mem_wd_q, mem_wd_d;

    logic                  split_q;
    logic                  legal_d;
    logic [DM_ADDRESS-1:0] beat0_addr;
    logic [3:0]            wr0, wr1;
    logic [DATA_W-1:0]     wd0, wd1, ld_data;

    lsu_lane_shift u_lane_shift (
        .funct3  (funct3_d),
        .offset  (addr_d[1:0]),
        .wdata   (wdata_d),
        .lo      (lo_d),
        .hi      (hi_d),
        .wr0     (wr0),
        .wr1     (wr1),
        .wd0     (wd0),
        .wd1     (wd1),
        .ld_data (ld_data)
    );

    // Next state, request capture and read-beat buffering.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        split_q  = is_split(funct3_q, addr_q[1:0]);

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    state_d  = is_legal(bus.req_write, bus.req_funct3) ? S_A0 : S_RESP;
                end
            end
            S_A0:    state_d = write_q ? (split_q ? S_A1 : S_RESP) : S_D0;
            S_D0: begin
                lo_d    = bus.mem_rd;
                state_d = split_q ? S_A1 : S_RESP;
            end
            S_A1:    state_d = write_q ? S_RESP : S_D1;
            S_D1: begin
                hi_d    = bus.mem_rd;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are precomputed for the state being entered so they leave flops.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = '0;
        mem_wr_d     = 4'b0000;
        mem_wd_d     = '0;
        legal_d      = is_legal(write_d, funct3_d);
        beat0_addr   = {addr_d[DM_ADDRESS-1:2], 2'b00};

        case (state_d)
            S_A0: begin
                mem_addr_d = beat0_addr;
                if (write_d) begin
                    mem_wr_d = wr0;
                    mem_wd_d = wd0;
                end
            end
            S_A1: begin
                mem_addr_d = beat0_addr + DM_ADDRESS'(WORD_BYTES);
                if (write_d) begin
                    mem_wr_d = wr1;
                    mem_wd_d = wd1;
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_err_d   = !legal_d;
                if (legal_d && !write_d) resp_rdata_d = ld_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 4'b0000;
            mem_wd_q     <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_wd     = mem_wd_q;
endmodule
